// File: rtl/processor_core.sv
// processor_core: 4-cycle multicycle ECE350 core with stepper port and switch-mapped load
`timescale 1ns/1ps
module processor_core #(
  parameter logic [11:0] SW_ADDR = 12'hFFF
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB,
  output logic        wren,
  output logic [31:0] address_dmem,
  output logic [31:0] data,
  input  logic [31:0] q_dmem,
  output logic [5:0]  JA,
  input  logic [15:0] SW,
  input  logic [31:0] reg_24,
  input  logic [31:0] reg_25
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;
  localparam logic [4:0] OP_R = 5'd0, OP_J = 5'd1, OP_BNE = 5'd2, OP_JAL = 5'd3, OP_JR = 5'd4,
                         OP_ADDI = 5'd5, OP_BLT = 5'd6, OP_SW = 5'd7, OP_LW = 5'd8,
                         OP_SETX = 5'd21, OP_BEX = 5'd22;
  state_t      r_state;
  logic [31:0] r_pc, r_ir, r_npc, r_res;
  logic [4:0]  r_wreg;
  logic        r_we, r_lw, r_swsel;
  logic [5:0]  r_ja;
  logic [31:0] w_sel_ir, w_a, w_b, w_n, w_t, w_sum, w_diff, w_addi, w_quo, w_res, w_npc;
  logic [63:0] w_prod;
  logic [4:0]  w_op, w_sop, w_rd, w_rs, w_rt, w_sh, w_alu, w_wreg;
  logic        w_we, w_add_ov, w_sub_ov, w_addi_ov, w_mul_ov, w_unused;
  // Selects come straight from the ROM word in DECODE so operands are ready by EXEC
  assign w_sel_ir = r_state == DECODE ? q_imem : r_ir;
  assign w_sop = w_sel_ir[31:27];
  assign ctrl_readRegA = w_sop == OP_BEX ? 5'd30 : w_sel_ir[21:17];
  assign ctrl_readRegB = w_sop == OP_R ? w_sel_ir[16:12] : w_sel_ir[26:22];
  assign w_op  = r_ir[31:27];
  assign w_rd  = r_ir[26:22];
  assign w_rs  = r_ir[21:17];
  assign w_rt  = r_ir[16:12];
  assign w_sh  = r_ir[11:7];
  assign w_alu = r_ir[6:2];
  assign w_n   = {{15{r_ir[16]}}, r_ir[16:0]};
  assign w_t   = {5'b0, r_ir[26:0]};
  assign w_a   = data_readRegA;
  assign w_b   = data_readRegB;
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;
  assign w_addi = w_a + w_n;
  assign w_prod = {{32{w_a[31]}}, w_a} * {{32{w_b[31]}}, w_b};
  assign w_quo  = w_b == 32'd0 ? 32'd0 : &w_b ? -w_a : 32'($signed(w_a) / $signed(w_b));
  assign w_add_ov  = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);
  assign w_sub_ov  = (w_a[31] != w_b[31]) && (w_diff[31] != w_a[31]);
  assign w_addi_ov = (w_a[31] == w_n[31]) && (w_addi[31] != w_a[31]);
  assign w_mul_ov  = w_prod[63:32] != {32{w_prod[31]}};
  assign w_unused  = ^{r_ir[1:0], w_sel_ir[11:0], reg_24[31:4], reg_25[31:2], w_rs, w_rt};
  // Execute-stage result, destination (r30 on exceptions) and next PC
  always_comb begin
    w_res = '0;
    w_wreg = w_rd;
    w_we = 1'b0;
    w_npc = r_pc + 32'd1;
    case (w_op)
      OP_R: begin
        w_we = w_alu <= 5'd7;
        case (w_alu)
          5'd0: {w_wreg, w_res} = w_add_ov ? {5'd30, 32'd1} : {w_rd, w_sum};
          5'd1: {w_wreg, w_res} = w_sub_ov ? {5'd30, 32'd3} : {w_rd, w_diff};
          5'd2: w_res = w_a & w_b;
          5'd3: w_res = w_a | w_b;
          5'd4: w_res = w_a << w_sh;
          5'd5: w_res = $signed(w_a) >>> w_sh;
          5'd6: {w_wreg, w_res} = w_mul_ov ? {5'd30, 32'd4} : {w_rd, w_prod[31:0]};
          5'd7: {w_wreg, w_res} = w_b == 32'd0 ? {5'd30, 32'd5} : {w_rd, w_quo};
          default: w_res = '0;
        endcase
      end
      OP_ADDI: begin
        w_we = 1'b1;
        {w_wreg, w_res} = w_addi_ov ? {5'd30, 32'd2} : {w_rd, w_addi};
      end
      OP_LW: w_we = 1'b1;
      OP_J: w_npc = w_t;
      OP_JAL: begin
        w_we = 1'b1;
        w_wreg = 5'd31;
        w_res = r_pc + 32'd1;
        w_npc = w_t;
      end
      OP_JR: w_npc = w_b;
      OP_BNE: w_npc = w_b != w_a ? r_pc + 32'd1 + w_n : r_pc + 32'd1;
      OP_BLT: w_npc = $signed(w_b) < $signed(w_a) ? r_pc + 32'd1 + w_n : r_pc + 32'd1;
      OP_SETX: begin
        w_we = 1'b1;
        w_wreg = 5'd30;
        w_res = w_t;
      end
      OP_BEX: w_npc = w_a != 32'd0 ? w_t : r_pc + 32'd1;
      default: w_we = 1'b0;
    endcase
  end
  assign address_imem     = r_pc;
  assign wren             = r_state == EXEC && w_op == OP_SW;
  assign address_dmem     = r_state == EXEC ? w_addi : 32'd0;
  assign data             = r_state == EXEC ? w_b : 32'd0;
  assign ctrl_writeEnable = r_we;
  assign ctrl_writeReg    = r_wreg;
  assign data_writeReg    = r_lw ? (r_swsel ? {16'b0, SW} : q_dmem) : r_res;
  assign JA               = r_ja;
  // Four-state sequencer; reset aborts any in-flight instruction and restarts at PC 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
      r_pc <= '0;
      r_ir <= '0;
      r_npc <= '0;
      r_res <= '0;
      r_wreg <= '0;
      r_we <= 1'b0;
      r_lw <= 1'b0;
      r_swsel <= 1'b0;
    end else begin
      case (r_state)
        FETCH: r_state <= DECODE;
        DECODE: begin
          r_ir <= q_imem;
          r_state <= EXEC;
        end
        EXEC: begin
          r_res <= w_res;
          r_wreg <= w_wreg;
          r_we <= w_we;
          r_lw <= w_op == OP_LW;
          r_swsel <= w_addi[11:0] == SW_ADDR;
          r_npc <= w_npc;
          r_state <= WB;
        end
        default: begin
          r_we <= 1'b0;
          r_pc <= r_npc;
          r_state <= FETCH;
        end
      endcase
    end
  end
  // Stepper outputs follow the r24/r25 taps one clock late
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_ja <= '0;
    else r_ja <= {reg_25[1:0], reg_24[3:0]};
  end
endmodule

// File: tb/tb_processor_core.sv
// tb_processor_core: scoreboard bench with ROM, regfile and RAM models around processor_core
`timescale 1ns/1ps
module tb_processor_core;
  logic clock = 1'b0, reset = 1'b1;
  logic [31:0] address_imem, q_imem, data_writeReg, data_readRegA, data_readRegB;
  logic [31:0] address_dmem, data, q_dmem, reg_24, reg_25;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic        ctrl_writeEnable, wren;
  logic [5:0]  JA;
  logic [15:0] SW = 16'd4;
  logic [31:0] rf [32] = '{default: 32'd0};
  logic [31:0] rom [64];
  logic [31:0] ram [16] = '{default: 32'd0};
  typedef struct {logic k; logic [31:0] a; logic [31:0] d;} item_t;
  item_t sb[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;

  processor_core dut (
    .clock(clock), .reset(reset), .address_imem(address_imem), .q_imem(q_imem),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_writeReg(data_writeReg), .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .wren(wren), .address_dmem(address_dmem), .data(data), .q_dmem(q_dmem),
    .JA(JA), .SW(SW), .reg_24(reg_24), .reg_25(reg_25)
  );

  always #5 clock = ~clock;

  assign data_readRegA = rf[ctrl_readRegA];
  assign data_readRegB = rf[ctrl_readRegB];
  assign reg_24 = rf[24];
  assign reg_25 = rf[25];

  always @(posedge clock) begin
    q_imem <= rom[address_imem[5:0]];
    q_dmem <= ram[address_dmem[3:0]];
    if (wren) ram[address_dmem[3:0]] <= data;
    if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fr(input int rd, input int rs, input int rt, input int sh, input int op);
    return {5'd0, rd[4:0], rs[4:0], rt[4:0], sh[4:0], op[4:0], 2'b0};
  endfunction
  function automatic logic [31:0] fi(input int op, input int rd, input int rs, input int imm);
    return {op[4:0], rd[4:0], rs[4:0], imm[16:0]};
  endfunction
  function automatic logic [31:0] fj(input int op, input int t);
    return {op[4:0], t[26:0]};
  endfunction

  task automatic ew(input int r, input logic [31:0] v);
    sb.push_back('{1'b0, 32'(r), v});
  endtask

  task automatic wait_pc(input logic [31:0] p);
    for (int i = 0; i < 2000 && address_imem !== p; i++) @(negedge clock);
    check("pc_reach", address_imem, p);
  endtask

  always @(negedge clock) begin
    item_t e;
    if (reset && (ctrl_writeEnable || wren)) begin
      check("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("kind", 32'(wren), 32'(e.k));
        if (e.k) begin
          check("mem_addr", address_dmem, e.a);
          check("mem_data", data, e.d);
          check("mem_phase", 32'(cyc % 4), 32'd2);
        end else begin
          check("wr_reg", 32'(ctrl_writeReg), e.a);
          check("wr_data", data_writeReg, e.d);
          check("wr_phase", 32'(cyc % 4), 32'd3);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = {5'b11111, 27'd0};
    rom[0]  = fi(5, 1, 0, 5);        ew(1, 5);
    rom[1]  = fi(5, 2, 0, 7);        ew(2, 7);
    rom[2]  = fr(3, 1, 2, 0, 0);     ew(3, 12);
    rom[3]  = fr(4, 2, 1, 0, 1);     ew(4, 2);
    rom[4]  = fi(7, 1, 0, 3);        sb.push_back('{1'b1, 32'd3, 32'd5});
    rom[5]  = fi(8, 5, 0, 3);        ew(5, 5);
    rom[6]  = fi(8, 6, 0, 4095);     ew(6, 4);
    rom[7]  = fi(8, 7, 0, 4095);     ew(7, 0);
    rom[8]  = fi(5, 1, 0, -1);       ew(1, 32'hFFFF_FFFF);
    rom[9]  = fi(5, 2, 0, 1);        ew(2, 1);
    rom[10] = fi(6, 1, 2, 1);
    rom[11] = fi(5, 8, 0, 99);
    rom[12] = fi(2, 1, 1, 5);
    rom[13] = fi(2, 1, 2, 1);
    rom[14] = fi(5, 8, 0, 77);
    rom[15] = fj(3, 20);             ew(31, 16);
    rom[20] = fi(5, 9, 0, 3);        ew(9, 3);
    rom[21] = fi(4, 31, 0, 0);
    rom[22] = fi(5, 8, 0, 55);
    rom[16] = fj(21, 9);             ew(30, 9);
    rom[17] = fj(22, 24);
    rom[18] = fi(5, 8, 0, 66);
    rom[24] = fi(5, 10, 0, 1);       ew(10, 1);
    rom[25] = fr(11, 10, 0, 30, 4);  ew(11, 32'h4000_0000);
    rom[26] = fi(5, 12, 11, -1);     ew(12, 32'h3FFF_FFFF);
    rom[27] = fr(13, 11, 12, 0, 0);  ew(13, 32'h7FFF_FFFF);
    rom[28] = fr(3, 13, 10, 0, 0);   ew(30, 1);
    rom[29] = fr(4, 13, 0, 0, 7);    ew(30, 5);
    rom[30] = fr(14, 10, 0, 31, 4);  ew(14, 32'h8000_0000);
    rom[31] = fr(15, 14, 10, 0, 1);  ew(30, 3);
    rom[32] = fi(5, 15, 13, 1);      ew(30, 2);
    rom[33] = fr(16, 11, 10, 0, 6);  ew(16, 32'h4000_0000);
    rom[34] = fr(17, 11, 11, 0, 6);  ew(30, 4);
    rom[35] = fi(5, 19, 0, -12);     ew(19, 32'hFFFF_FFF4);
    rom[36] = fi(5, 20, 0, 5);       ew(20, 5);
    rom[37] = fr(18, 19, 20, 0, 7);  ew(18, 32'hFFFF_FFFE);
    rom[38] = fr(21, 19, 20, 0, 2);  ew(21, 4);
    rom[39] = fr(22, 19, 20, 0, 3);  ew(22, 32'hFFFF_FFF5);
    rom[40] = fr(23, 14, 0, 4, 5);   ew(23, 32'hF800_0000);
    rom[41] = fr(8, 1, 2, 0, 8);
    rom[42] = fi(5, 24, 0, 10);      ew(24, 10);
    rom[43] = fi(5, 25, 0, 3);       ew(25, 3);
    rom[44] = fi(5, 0, 0, 1);        ew(0, 1);
    rom[45] = fj(1, 50);
    rom[50] = fi(7, 1, 0, 0);
    #1 reset = 1'b0;
    #0.5;
    check("rst_imem", address_imem, 32'd0);
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_we", 32'(ctrl_writeEnable), 32'd0);
    check("rst_ja", 32'(JA), 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_dmem", address_dmem, 32'd0);
    check("rst_wdata", data_writeReg, 32'd0);
    #0.5 reset = 1'b1;
    wait_pc(32'd7);
    SW = 16'd0;
    for (int i = 0; i < 2000 && !(ctrl_writeEnable && ctrl_writeReg == 5'd25); i++) @(negedge clock);
    check("r25_write", 32'(ctrl_writeReg), 32'd25);
    @(negedge clock);
    check("ja_before", 32'(JA), 32'h0A);
    @(negedge clock);
    check("ja_after", 32'(JA), 32'h3A);
    wait_pc(32'd50);
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("abort_wren", 32'(wren), 32'd0);
    check("abort_pc", address_imem, 32'd0);
    check("abort_dmem", address_dmem, 32'd0);
    #1 reset = 1'b1;
    @(negedge clock);
    check("restart_pc0", address_imem, 32'd0);
    @(negedge clock);
    check("restart_pc1", address_imem, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
